arith_mac_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's trivial add/multiply datapath.
- Per accepted operand triple it computes:
  - a three-operand sum;
  - a full-width product;
  - a running, saturating multiply-accumulate selected per transaction by a mode field.
- Sits between a valid/ready producer and consumer in Chisel-generated test designs. Exercises width inference and pipelining in the FIRRTL flow.

---
 rtl/arith_mac_pipe_pkg.sv | 22 ++
 rtl/arith_mac_pipe_if.sv | 33 +++
 rtl/arith_mac_pipe_sat_acc.sv | 57 +++++
 rtl/arith_mac_pipe.sv | 101 ++++++++++
 tb/tb_arith_mac_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_mac_pipe_pkg.sv
// Shared types and width helpers for the arith_mac_pipe datapath.
package arith_pkg;

    // Per-transaction accumulator operation.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_ACC   = 2'd1,
        MODE_LOAD  = 2'd2,
        MODE_CLEAR = 2'd3
    } mode_e;

    // Three-operand sum never overflows at operand width + 2.
    function automatic int unsigned sum_width(input int unsigned w);
        return w + 2;
    endfunction

    // Full-width product of two operands.
    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/arith_mac_pipe_if.sv
// Valid/ready operand and result bundle for arith_mac_pipe.
interface arith_mac_pipe_if
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 24
);
    logic                             in_valid;
    logic                             in_ready;
    logic [WIDTH-1:0]                 in_value1;
    logic [WIDTH-1:0]                 in_value2;
    logic [WIDTH-1:0]                 in_value3;
    mode_e                            in_mode;
    logic                             out_valid;
    logic                             out_ready;
    logic [sum_width(WIDTH)-1:0]      out_add;
    logic [prod_width(WIDTH)-1:0]     out_mul;
    logic [ACC_WIDTH-1:0]             out_acc;
    logic                             out_sat;

    // Producer/consumer side.
    modport master (
        output in_valid, in_value1, in_value2, in_value3, in_mode, out_ready,
        input  in_ready, out_valid, out_add, out_mul, out_acc, out_sat
    );

    // Datapath side.
    modport slave (
        input  in_valid, in_value1, in_value2, in_value3, in_mode, out_ready,
        output in_ready, out_valid, out_add, out_mul, out_acc, out_sat
    );

endinterface

// File: rtl/arith_mac_pipe_sat_acc.sv
// Saturating accumulator with sticky saturation flag; one update per enable.
module arith_sat_acc
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          i_en,
    input  mode_e                         i_mode,
    input  logic [prod_width(WIDTH)-1:0]  i_product,
    output logic [ACC_WIDTH-1:0]          o_acc,
    output logic                          o_sat
);
    localparam int unsigned EXT_W = ACC_WIDTH + 1;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_sat;
    logic [EXT_W-1:0]     w_ext_sum;

    // Carry out of the extended sum signals overflow.
    assign w_ext_sum = {1'b0, r_acc} + EXT_W'(i_product);

    // Apply the transaction's accumulator operation when enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            case (i_mode)
                MODE_PASS: ;
                MODE_ACC: begin
                    if (w_ext_sum[ACC_WIDTH]) begin
                        r_acc <= '1;
                        r_sat <= 1'b1;
                    end else begin
                        r_acc <= w_ext_sum[ACC_WIDTH-1:0];
                    end
                end
                MODE_LOAD: begin
                    r_acc <= ACC_WIDTH'(i_product);
                    r_sat <= 1'b0;
                end
                MODE_CLEAR: begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/arith_mac_pipe.sv
// Two-stage valid/ready pipeline: sum, product and saturating MAC per transaction.
module arith_mac_pipe
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    arith_mac_pipe_if.slave  bus
);
    localparam int unsigned SUM_W  = sum_width(WIDTH);
    localparam int unsigned PROD_W = prod_width(WIDTH);

    if (WIDTH < 2) begin : g_chk_width
        $error("arith_mac_pipe: WIDTH must be >= 2");
    end
    if (ACC_WIDTH < PROD_W) begin : g_chk_acc_width
        $error("arith_mac_pipe: ACC_WIDTH must be >= 2*WIDTH");
    end

    logic              r_s1_valid;
    logic [SUM_W-1:0]  r_s1_sum;
    logic [PROD_W-1:0] r_s1_prod;
    mode_e             r_s1_mode;
    logic              r_s2_valid;
    logic [SUM_W-1:0]  r_s2_add;
    logic [PROD_W-1:0] r_s2_mul;

    logic              w_s2_free;
    logic              w_s1_free;
    logic              w_in_fire;
    logic              w_s1_adv;
    logic [SUM_W-1:0]  w_sum;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_WIDTH-1:0] w_acc;
    logic              w_sat;

    assign w_s2_free = !r_s2_valid || bus.out_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign w_in_fire = bus.in_valid && w_s1_free;
    assign w_s1_adv  = r_s1_valid && w_s2_free;

    assign w_sum  = SUM_W'(bus.in_value1) + SUM_W'(bus.in_value2) + SUM_W'(bus.in_value3);
    assign w_prod = PROD_W'(bus.in_value1) * PROD_W'(bus.in_value2);

    // Stage 1: capture sum, product and mode on input transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_prod  <= '0;
            r_s1_mode  <= MODE_PASS;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_sum   <= w_sum;
            r_s1_prod  <= w_prod;
            r_s1_mode  <= bus.in_mode;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result registers, loaded when stage 1 advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_add   <= '0;
            r_s2_mul   <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_add   <= r_s1_sum;
            r_s2_mul   <= r_s1_prod;
        end else if (bus.out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // The accumulator only changes on stage-2 load, so it doubles as the
    // stage-2 acc/sat output register and holds stable across stalls.
    arith_sat_acc #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_en      (w_s1_adv),
        .i_mode    (r_s1_mode),
        .i_product (r_s1_prod),
        .o_acc     (w_acc),
        .o_sat     (w_sat)
    );

    assign bus.in_ready  = w_s1_free;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_add   = r_s2_add;
    assign bus.out_mul   = r_s2_mul;
    assign bus.out_acc   = w_acc;
    assign bus.out_sat   = w_sat;

endmodule

// File: tb/tb_arith_mac_pipe.sv
// Self-checking bench for arith_mac_pipe: directed scenarios plus randomized traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_arith_mac_pipe;
    import arith_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 24;
    localparam longint unsigned ACC_MAX = (64'd1 << AW) - 64'd1;

    typedef struct {
        longint unsigned add;
        longint unsigned mul;
        longint unsigned acc;
        bit              sat;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    arith_mac_pipe_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

    arith_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    exp_t            exp_q[$];
    logic [63:0]     obs_acc[$];
    logic            obs_sat[$];
    longint unsigned m_acc = 0;
    bit              m_sat = 0;

    bit          hold_pending = 0;
    logic [63:0] h_add, h_mul, h_acc;
    logic        h_sat;
    bit          last_accepted;
    logic        s_in_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: whole-transaction arithmetic in accept order.
    task automatic model_accept(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned mode);
        exp_t e;
        e.add = longint'(a) + longint'(b) + longint'(c);
        e.mul = longint'(a) * longint'(b);
        case (mode)
            1: begin
                if (m_acc + e.mul > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_sat = 1;
                end else begin
                    m_acc = m_acc + e.mul;
                end
            end
            2: begin m_acc = e.mul; m_sat = 0; end
            3: begin m_acc = 0;     m_sat = 0; end
            default: ;
        endcase
        e.acc = m_acc;
        e.sat = m_sat;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive at negedge, sample just after, score transfers.
    task automatic step(input bit v, input int unsigned a, input int unsigned b,
                        input int unsigned c, input int unsigned mode, input bit ordy);
        logic [31:0] av, bv, cv, mv;
        exp_t e;
        av = a; bv = b; cv = c; mv = mode;
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_value1 = av[W-1:0];
        bus.in_value2 = bv[W-1:0];
        bus.in_value3 = cv[W-1:0];
        bus.in_mode   = mode_e'(mv[1:0]);
        bus.out_ready = ordy;
        #1;
        s_in_ready = bus.in_ready;
        if (hold_pending) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_add", 64'(bus.out_add), h_add);
            check("hold_mul", 64'(bus.out_mul), h_mul);
            check("hold_acc", 64'(bus.out_acc), h_acc);
            check("hold_sat", 64'(bus.out_sat), 64'(h_sat));
        end
        hold_pending = 0;
        if (bus.out_valid === 1'b1) begin
            if (ordy) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_add", 64'(bus.out_add), e.add);
                    check("out_mul", 64'(bus.out_mul), e.mul);
                    check("out_acc", 64'(bus.out_acc), e.acc);
                    check("out_sat", 64'(bus.out_sat), 64'(e.sat));
                    obs_acc.push_back(64'(bus.out_acc));
                    obs_sat.push_back(bus.out_sat);
                end
            end else begin
                hold_pending = 1;
                h_add = 64'(bus.out_add);
                h_mul = 64'(bus.out_mul);
                h_acc = 64'(bus.out_acc);
                h_sat = bus.out_sat;
            end
        end
        last_accepted = v && (s_in_ready === 1'b1);
        if (last_accepted) model_accept(a, b, c, mode);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(0, 0, 0, 0, 0, 1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [63:0] eacc, input logic esat);
        if (idx < obs_acc.size()) begin
            check({tag, "_acc"}, obs_acc[idx], eacc);
            check({tag, "_sat"}, 64'(obs_sat[idx]), 64'(esat));
        end else begin
            check({tag, "_missing"}, 64'(obs_acc.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int acc_cnt;
        int cyc;
        bit v, ordy;
        int unsigned r, mode, a, b, c;

        // Reset state
        reset_n       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_value1 = '0;
        bus.in_value2 = '0;
        bus.in_value3 = '0;
        bus.in_mode   = MODE_PASS;
        bus.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_acc", 64'(bus.out_acc), 64'd0);
        check("rst_out_sat", 64'(bus.out_sat), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        check("rst_in_ready", 64'(s_in_ready), 64'd1);
        check("rst_out_valid2", 64'(bus.out_valid), 64'd0);

        // PASS with latency check
        obs_acc.delete(); obs_sat.delete();
        step(1, 200, 100, 255, MODE_PASS, 1);
        check("pass_accept", 64'(last_accepted), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        check("pass_lat1_valid", 64'(bus.out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 1);
        check("pass_lat2_valid", 64'(bus.out_valid), 64'd1);
        check("pass_add", 64'(bus.out_add), 64'd555);
        check("pass_mul", 64'(bus.out_mul), 64'd20000);
        check("pass_acc", 64'(bus.out_acc), 64'd0);
        drain();

        // LOAD / ACC sequence
        obs_acc.delete(); obs_sat.delete();
        step(1, 3, 4, 0, MODE_LOAD, 1);
        step(1, 5, 6, 0, MODE_ACC, 1);
        step(1, 255, 255, 0, MODE_ACC, 1);
        drain();
        check_obs("seq0", 0, 64'd12, 1'b0);
        check_obs("seq1", 1, 64'd42, 1'b0);
        check_obs("seq2", 2, 64'd65067, 1'b0);

        // Saturation, exact-max boundary, stickiness, clear
        obs_acc.delete(); obs_sat.delete();
        step(1, 255, 255, 0, MODE_LOAD, 1);
        for (int i = 0; i < 257; i++) step(1, 255, 255, 0, MODE_ACC, 1);
        step(1, 3, 255, 0, MODE_ACC, 1);
        step(1, 255, 255, 0, MODE_ACC, 1);
        step(1, 1, 1, 0, MODE_ACC, 1);
        step(1, 0, 0, 0, MODE_PASS, 1);
        step(1, 0, 0, 0, MODE_CLEAR, 1);
        drain();
        check("sat_count", 64'(obs_acc.size()), 64'd263);
        check_obs("sat_load", 0, 64'd65025, 1'b0);
        check_obs("sat_pre", 257, 64'd16776450, 1'b0);
        check_obs("sat_exact_max", 258, 64'd16777215, 1'b0);
        check_obs("sat_overflow", 259, 64'd16777215, 1'b1);
        check_obs("sat_stay", 260, 64'd16777215, 1'b1);
        check_obs("sat_pass", 261, 64'd16777215, 1'b1);
        check_obs("sat_clear", 262, 64'd0, 1'b0);

        // Backpressure with continuous ACC(1,1)
        step(1, 0, 0, 0, MODE_CLEAR, 1);
        drain();
        obs_acc.delete(); obs_sat.delete();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 0, MODE_ACC, 0);
            check($sformatf("bp_in_ready%0d", i), 64'(s_in_ready), (i < 2) ? 64'd1 : 64'd0);
            if (last_accepted) n_acc++;
        end
        check("bp_accepted", 64'(n_acc), 64'd2);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 0, MODE_ACC, 1);
            if (last_accepted) n_acc++;
        end
        drain();
        check("bp_count", 64'(obs_acc.size()), 64'(n_acc));
        for (int i = 0; i < n_acc; i++) check_obs($sformatf("bp_seq%0d", i), i, 64'(i + 1), 1'b0);

        // Asynchronous reset mid-stream
        step(1, 1, 1, 1, MODE_ACC, 0);
        step(1, 1, 1, 1, MODE_ACC, 0);
        @(posedge clock);
        #3;
        check("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_acc", 64'(bus.out_acc), 64'd0);
        check("mid_rst_sat", 64'(bus.out_sat), 64'd0);
        exp_q.delete();
        m_acc = 0;
        m_sat = 0;
        hold_pending = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 1);
        check("mid_in_ready", 64'(s_in_ready), 64'd1);
        check("mid_out_valid", 64'(bus.out_valid), 64'd0);

        // Randomized traffic against the reference model
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            v    = ($urandom_range(0, 99) < 80);
            ordy = ($urandom_range(0, 99) < 75);
            r    = $urandom_range(0, 999);
            mode = (r < 150) ? 0 : (r < 990) ? 1 : (r < 995) ? 2 : 3;
            a = ($urandom_range(0, 1) == 0) ? 255 : $urandom_range(0, 255);
            b = ($urandom_range(0, 1) == 0) ? 255 : $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            step(v, a, b, c, mode, ordy);
            if (last_accepted) acc_cnt++;
            cyc++;
        end
        check("rand_accepted", 64'(acc_cnt), 64'd10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
